// File: rtl/atom_pkg.sv
// Shared constants and FSM encoding for the SPI boot loader.
`timescale 1ns/1ps
package atom_pkg;

   localparam int unsigned AddrWDef         = 18;
   localparam int unsigned BootStartAddrDef = 32'h0000_C000;
   localparam int unsigned BootEndAddrDef   = 32'h0000_FFFF;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRecv = 2'd1,
      StDone = 2'd2
   } boot_state_e;

endpackage

// File: rtl/spi_boot_loader_if.sv
// SRAM write port between the boot loader (master) and the SRAM arbiter (slave).
`timescale 1ns/1ps
interface spi_boot_loader_if #(
   parameter int unsigned ADDR_W = 18
);
   logic              wr_req;
   logic              wr_ack;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;

   modport master (output wr_req, output wr_addr, output wr_data, input wr_ack);
   modport slave  (input wr_req, input wr_addr, input wr_data, output wr_ack);
endinterface

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous pin plus rise/fall detection.
`timescale 1ns/1ps
module sync_edge #(
   parameter logic ResetVal = 1'b0
) (
   input  logic clk,
   input  logic reset_b,
   input  logic d_i,
   output logic sync_o,
   output logic rise_o,
   output logic fall_o
);

   logic meta_q, sync_q, prev_q;

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         meta_q <= ResetVal;
         sync_q <= ResetVal;
         prev_q <= ResetVal;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign sync_o = sync_q;
   assign rise_o = sync_q & ~prev_q;
   assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/spi_boot_loader.sv
// Receives the boot image over SPI and writes it byte-by-byte into SRAM, holding the CPU
// in reset (booting) until the whole image window has been written.
`timescale 1ns/1ps
module spi_boot_loader
   import atom_pkg::*;
#(
   parameter int unsigned ADDR_W          = AddrWDef,
   parameter int unsigned BOOT_START_ADDR = BootStartAddrDef,
   parameter int unsigned BOOT_END_ADDR   = BootEndAddrDef
) (
   input  logic              clk,
   input  logic              reset_b,
   input  logic              arm_ss,
   input  logic              arm_sclk,
   input  logic              arm_mosi,
   spi_boot_loader_if.master wr_bus,
   output logic              booting,
   output logic              overrun
);

   localparam logic [ADDR_W-1:0] StartAddr = ADDR_W'(BOOT_START_ADDR);
   localparam logic [ADDR_W-1:0] EndAddr   = ADDR_W'(BOOT_END_ADDR);

   boot_state_e       state_q, state_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic [7:0]        shift_q, shift_d;
   logic              wr_req_q, wr_req_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [7:0]        wr_data_q, wr_data_d;
   logic              booting_q, booting_d;
   logic              overrun_q, overrun_d;
   logic              mosi_meta_q, mosi_sync_q;

   logic              ss_sync, ss_rise, ss_fall;
   logic              sclk_sync, sclk_rise, sclk_fall;
   logic              unused_edges;

   sync_edge #(.ResetVal(1'b1)) u_sync_ss (
      .clk     (clk),
      .reset_b (reset_b),
      .d_i     (arm_ss),
      .sync_o  (ss_sync),
      .rise_o  (ss_rise),
      .fall_o  (ss_fall)
   );

   sync_edge #(.ResetVal(1'b1)) u_sync_sclk (
      .clk     (clk),
      .reset_b (reset_b),
      .d_i     (arm_sclk),
      .sync_o  (sclk_sync),
      .rise_o  (sclk_rise),
      .fall_o  (sclk_fall)
   );

   assign unused_edges = ss_fall ^ sclk_fall ^ sclk_sync;

   // Write state as it will be after this cycle's ack, so a same-cycle ack counts as done.
   logic              ack_now;
   logic              pending_after;
   logic [ADDR_W-1:0] addr_after;
   logic              img_done;

   assign ack_now       = wr_req_q & wr_bus.wr_ack;
   assign pending_after = wr_req_q & ~wr_bus.wr_ack;
   assign addr_after    = ack_now ? wr_addr_q + 1'b1 : wr_addr_q;
   assign img_done      = (addr_after > EndAddr) && !pending_after;

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state_q     <= StIdle;
         bit_cnt_q   <= 3'd0;
         shift_q     <= 8'd0;
         wr_req_q    <= 1'b0;
         wr_addr_q   <= StartAddr;
         wr_data_q   <= 8'd0;
         booting_q   <= 1'b1;
         overrun_q   <= 1'b0;
         mosi_meta_q <= 1'b0;
         mosi_sync_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         wr_req_q    <= wr_req_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         booting_q   <= booting_d;
         overrun_q   <= overrun_d;
         mosi_meta_q <= arm_mosi;
         mosi_sync_q <= mosi_meta_q;
      end
   end

   // A new session waits for any leftover write so the address restart cannot corrupt it.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (!ss_sync && !wr_req_q) state_d = StRecv;
         StRecv:  if (ss_rise) state_d = img_done ? StDone : StIdle;
         StDone:  state_d = StDone;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      wr_req_d  = wr_req_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      booting_d = booting_q;
      overrun_d = overrun_q;

      if (ack_now) begin
         wr_req_d  = 1'b0;
         wr_addr_d = addr_after;
      end

      unique case (state_q)
         StIdle: begin
            if (state_d == StRecv) begin
               bit_cnt_d = 3'd0;
               shift_d   = 8'd0;
               wr_addr_d = StartAddr;
            end
         end
         StRecv: begin
            if (ss_rise) begin
               bit_cnt_d = 3'd0;
               shift_d   = 8'd0;
               if (img_done) booting_d = 1'b0;
            end else if (sclk_rise) begin
               shift_d   = {shift_q[6:0], mosi_sync_q};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  if (addr_after > EndAddr) begin
                     wr_req_d = wr_req_d;
                  end else if (pending_after) begin
                     overrun_d = 1'b1;
                  end else begin
                     wr_req_d  = 1'b1;
                     wr_data_d = shift_d;
                  end
               end
            end
         end
         default: begin
            bit_cnt_d = bit_cnt_q;
         end
      endcase
   end

   assign wr_bus.wr_req  = wr_req_q;
   assign wr_bus.wr_addr = wr_addr_q;
   assign wr_bus.wr_data = wr_data_q;
   assign booting        = booting_q;
   assign overrun        = overrun_q;

endmodule

// File: tb/tb_spi_boot_loader.sv
// Randomised SPI image transfers against a queue-based model of the expected SRAM writes.
`timescale 1ns/1ps
module tb_spi_boot_loader;

   localparam int unsigned AddrW = 18;
   localparam int unsigned Start = 32'h0000_C000;
   localparam int unsigned End   = 32'h0000_C00F;
   localparam int          Depth = int'(End - Start + 1);

   logic clk = 1'b0;
   logic reset_b = 1'b0;
   logic arm_ss = 1'b1;
   logic arm_sclk = 1'b1;
   logic arm_mosi = 1'b0;
   logic booting, overrun;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0]  sent[$];
   logic [31:0] wa[$];
   logic [31:0] wd[$];
   int          ack_dly = 3;
   int          slow_idx = -1;
   int          wait_cnt = 0;
   logic        unstable = 1'b0;
   logic [31:0] hold_addr = '0;
   logic [31:0] hold_data = '0;

   spi_boot_loader_if #(.ADDR_W(AddrW)) bus ();

   spi_boot_loader #(
      .ADDR_W          (AddrW),
      .BOOT_START_ADDR (Start),
      .BOOT_END_ADDR   (End)
   ) dut (
      .clk      (clk),
      .reset_b  (reset_b),
      .arm_ss   (arm_ss),
      .arm_sclk (arm_sclk),
      .arm_mosi (arm_mosi),
      .wr_bus   (bus.master),
      .booting  (booting),
      .overrun  (overrun)
   );

   always #5 clk = ~clk;

   // Arbiter model: acks ack_dly cycles after the request (60 for write number slow_idx).
   initial begin
      bus.wr_ack = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.wr_ack) begin
            bus.wr_ack = 1'b0;
         end else if (reset_b && bus.wr_req) begin
            if (wait_cnt == 0) begin
               hold_addr = 32'(bus.wr_addr);
               hold_data = 32'(bus.wr_data);
            end else if (32'(bus.wr_addr) !== hold_addr || 32'(bus.wr_data) !== hold_data) begin
               unstable = 1'b1;
            end
            if (wait_cnt >= ((wa.size() == slow_idx) ? 60 : ack_dly)) begin
               bus.wr_ack = 1'b1;
               wa.push_back(32'(bus.wr_addr));
               wd.push_back(32'(bus.wr_data));
               wait_cnt = 0;
            end else begin
               wait_cnt++;
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, " wr_req"},  32'(bus.wr_req),  32'd0);
      check({tag, " wr_addr"}, 32'(bus.wr_addr), Start);
      check({tag, " wr_data"}, 32'(bus.wr_data), 32'd0);
      check({tag, " booting"}, 32'(booting),     32'd1);
      check({tag, " overrun"}, 32'(overrun),     32'd0);
   endtask

   task automatic clear_log();
      sent.delete();
      wa.delete();
      wd.delete();
      unstable = 1'b0;
   endtask

   task automatic do_reset();
      reset_b = 1'b0;
      #30;
      reset_b = 1'b1;
      #30;
      clear_log();
   endtask

   // 20 MHz SCLK: data changes on the falling edge, 25 ns per half period.
   task automatic spi_bits(input logic [7:0] b, input int nbits);
      for (int i = 7; i > 7 - nbits; i--) begin
         arm_sclk = 1'b0;
         arm_mosi = b[i];
         #25;
         arm_sclk = 1'b1;
         #25;
      end
   endtask

   task automatic send_bytes(input int n);
      logic [7:0] b;
      for (int k = 0; k < n; k++) begin
         b = 8'($urandom);
         sent.push_back(b);
         spi_bits(b, 8);
      end
   endtask

   task automatic ss_open();
      arm_ss = 1'b0;
      #60;
   endtask

   task automatic ss_close();
      #200;
      arm_ss = 1'b1;
      #200;
   endtask

   // Model: bytes in send order, minus the dropped one, up to the window size, at Start+i.
   task automatic verify(input string tag, input int drop);
      logic [7:0] exp[$];
      foreach (sent[i]) begin
         if (i != drop && exp.size() < Depth) exp.push_back(sent[i]);
      end
      check({tag, " write count"}, 32'(wa.size()), 32'(exp.size()));
      for (int i = 0; i < exp.size() && i < wa.size(); i++) begin
         check($sformatf("%s addr[%0d]", tag, i), wa[i], Start + 32'(i));
         check($sformatf("%s data[%0d]", tag, i), wd[i], 32'(exp[i]));
      end
      check({tag, " handshake stable"}, 32'(unstable), 32'd0);
   endtask

   initial begin
      #23;
      check_reset_vals("reset");
      reset_b = 1'b1;
      #20;

      // Full image.
      clear_log();
      ss_open();
      send_bytes(Depth);
      ss_close();
      verify("full", -1);
      check("full booting", 32'(booting), 32'd0);
      check("full overrun", 32'(overrun), 32'd0);

      // Single byte then ss high, followed by a fresh full transfer without reset.
      do_reset();
      ss_open();
      sent.push_back(8'hA5);
      spi_bits(8'hA5, 8);
      ss_close();
      verify("short", -1);
      check("short booting", 32'(booting), 32'd1);
      clear_log();
      ss_open();
      send_bytes(Depth);
      ss_close();
      verify("refill", -1);
      check("refill booting", 32'(booting), 32'd0);

      // Slow ack on the second write: third byte is dropped.
      do_reset();
      slow_idx = 1;
      ss_open();
      send_bytes(3);
      check("slow wr_req held", 32'(bus.wr_req), 32'd1);
      check("slow wr_addr held", 32'(bus.wr_addr), Start + 32'd1);
      send_bytes(Depth - 3);
      ss_close();
      slow_idx = -1;
      verify("slow", 2);
      check("slow overrun", 32'(overrun), 32'd1);
      check("slow booting", 32'(booting), 32'd1);

      // Oversized image.
      do_reset();
      ss_open();
      send_bytes(Depth + 2);
      ss_close();
      verify("oversize", -1);
      check("oversize booting", 32'(booting), 32'd0);
      check("oversize overrun", 32'(overrun), 32'd0);

      // Asynchronous reset mid-transfer, then retransmission.
      do_reset();
      ss_open();
      send_bytes(5);
      #6;
      reset_b = 1'b0;
      #1;
      check_reset_vals("midreset");
      arm_ss = 1'b1;
      #100;
      reset_b = 1'b1;
      #50;
      clear_log();
      ss_open();
      send_bytes(Depth);
      ss_close();
      verify("retx", -1);
      check("retx booting", 32'(booting), 32'd0);

      // Trailing partial byte after a full image.
      do_reset();
      ss_open();
      send_bytes(Depth);
      #200;
      spi_bits(8'hFF, 4);
      ss_close();
      verify("partial", -1);
      check("partial booting", 32'(booting), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
